// File: rtl/spi_master_core.sv
// Byte-oriented SPI master with CPOL/CPHA modes and programmable SCLK divider.
// One word per start request; reports completion with a done pulse.
module spi_master_core #(
  parameter int DATA_W    = 8,
  parameter int DIV_W     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              miso,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              mosi,
  output logic              cs_n
);

  localparam int EW = $clog2(2 * DATA_W);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  hcnt;
  logic              pol_q;
  logic              pha_q;
  logic [EW-1:0]     ecnt;
  logic              tick;
  logic              lead;
  logic              last;
  logic              smp;
  logic              adv;

  function automatic logic nbit(input logic [DATA_W-1:0] w);
    return LSB_FIRST ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] drop(input logic [DATA_W-1:0] w);
    return LSB_FIRST ? (w >> 1) : (w << 1);
  endfunction

  function automatic logic [DATA_W-1:0] cap(
    input logic [DATA_W-1:0] w,
    input logic              b
  );
    return LSB_FIRST ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
  endfunction

  // half-period tick and per-edge sample/shift decisions
  assign tick = (hcnt == div_q);
  assign lead = ~ecnt[0];
  assign last = (ecnt == EW'(2 * DATA_W - 1));
  assign smp  = tick && (state == XFER) && (lead ^ pha_q);
  assign adv  = tick && (state == XFER) &&
                (pha_q ? lead : (~lead && ~last));

  // transfer sequencer with registered SPI pins and status
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      rx_data <= '0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      cs_n    <= 1'b1;
      tx_sh   <= '0;
      rx_sh   <= '0;
      div_q   <= '0;
      hcnt    <= '0;
      pol_q   <= 1'b0;
      pha_q   <= 1'b0;
      ecnt    <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          sclk <= cpol;
          mosi <= 1'b0;
          cs_n <= 1'b1;
          hcnt <= '0;
          ecnt <= '0;
          if (start) begin
            state <= SETUP;
            busy  <= 1'b1;
            cs_n  <= 1'b0;
            div_q <= clk_div;
            pol_q <= cpol;
            pha_q <= cpha;
            rx_sh <= '0;
            if (!cpha) begin
              mosi  <= nbit(tx_data);
              tx_sh <= drop(tx_data);
            end else begin
              tx_sh <= tx_data;
            end
          end
        end
        SETUP: begin
          hcnt <= tick ? '0 : hcnt + 1'b1;
          if (tick) state <= XFER;
        end
        XFER: begin
          hcnt <= tick ? '0 : hcnt + 1'b1;
          if (tick) begin
            sclk <= ~sclk;
            ecnt <= ecnt + 1'b1;
            if (smp) rx_sh <= cap(rx_sh, miso);
            if (adv) begin
              mosi  <= nbit(tx_sh);
              tx_sh <= drop(tx_sh);
            end
            if (last) begin
              state <= HOLD;
              ecnt  <= '0;
            end
          end
        end
        HOLD: begin
          hcnt <= tick ? '0 : hcnt + 1'b1;
          if (tick) begin
            state   <= IDLE;
            busy    <= 1'b0;
            cs_n    <= 1'b1;
            done    <= 1'b1;
            rx_data <= rx_sh;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_core.sv
// Bench for spi_master_core: directed and random transfers checked
// against a bit-level SPI slave/observer model.
module tb_spi_master_core;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] tx_data = '0;
  logic [7:0] clk_div = '0;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
  logic       miso;
  logic       miso_s = 1'b0;
  logic       busy, done, sclk, mosi, cs_n;
  logic [7:0] rx_data;
  logic       busy_l, done_l, sclk_l, mosi_l, cs_n_l;
  logic [7:0] rx_l;

  int checks = 0;
  int errors = 0;

  bit         loop = 1'b1;
  bit         m_pol = 1'b0;
  bit         m_pha = 1'b0;
  logic [7:0] s_word = '0;
  int n_rise = 0, n_fall = 0, n_lead = 0, n_trail = 0;
  int n_busy = 0, n_done = 0, cyc = 0, e_first = 0, e_last = 0;
  int idx;
  logic sclk_q = 1'b0;
  bit mbits[$];
  bit lbits[$];

  always #5 clk = ~clk;

  assign miso = loop ? mosi : miso_s;

  spi_master_core #(.DATA_W(8), .DIV_W(8), .LSB_FIRST(1'b0)) u_dut (
    .clk(clk), .rst(rst), .start(start), .tx_data(tx_data),
    .clk_div(clk_div), .cpol(cpol), .cpha(cpha), .miso(miso),
    .busy(busy), .done(done), .rx_data(rx_data),
    .sclk(sclk), .mosi(mosi), .cs_n(cs_n)
  );

  spi_master_core #(.DATA_W(8), .DIV_W(8), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .start(start), .tx_data(tx_data),
    .clk_div(clk_div), .cpol(cpol), .cpha(cpha), .miso(mosi_l),
    .busy(busy_l), .done(done_l), .rx_data(rx_l),
    .sclk(sclk_l), .mosi(mosi_l), .cs_n(cs_n_l)
  );

  // observer + slave: classify sclk edges, record sampled mosi bits,
  // and present the slave word MSB-first on its shift edges
  always @(negedge clk) begin
    cyc++;
    if (!cs_n && sclk !== sclk_q) begin
      if (sclk) n_rise++;
      else n_fall++;
      if (n_rise + n_fall == 1) e_first = cyc;
      e_last = cyc;
      if (sclk !== m_pol) begin
        n_lead++;
        if (!m_pha) begin
          mbits.push_back(mosi);
          lbits.push_back(mosi_l);
        end
      end else begin
        n_trail++;
        if (m_pha) begin
          mbits.push_back(mosi);
          lbits.push_back(mosi_l);
        end
      end
    end
    sclk_q = sclk;
    if (busy) n_busy++;
    if (done) n_done++;
    idx = m_pha ? ((n_lead == 0) ? 0 : n_lead - 1) : n_trail;
    if (idx > N - 1) idx = N - 1;
    miso_s = s_word[N-1-idx];
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear();
    n_rise = 0; n_fall = 0; n_lead = 0; n_trail = 0;
    n_busy = 0; n_done = 0; e_first = 0; e_last = 0;
    mbits.delete();
    lbits.delete();
  endtask

  task automatic xfer(input logic [7:0] tx, input logic [7:0] div,
                      input bit pol, input bit pha, input bit lp,
                      input logic [7:0] sw, input bit poke);
    int h, i, lim;
    logic [7:0] er, mw, lw;
    h = int'(div) + 1;
    lim = (2 * N + 2) * h + 10;
    @(negedge clk);
    cpol = pol; cpha = pha; clk_div = div; tx_data = tx;
    loop = lp; s_word = sw; m_pol = pol; m_pha = pha;
    @(negedge clk);
    clear();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    i = 1;
    while (done !== 1'b1 && i < lim) begin
      if (poke && i == 5) begin
        start = 1'b1; tx_data = 8'hFF; clk_div = '0;
        cpol = ~pol; cpha = ~pha;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      i++;
    end
    start = 1'b0;
    er = lp ? tx : sw;
    chk("latency", i, (2 * N + 2) * h + 1);
    chk("rx_data", rx_data, er);
    chk("sclk_idle", sclk, pol);
    chk("cs_n_end", cs_n, 1);
    chk("busy_cycles", n_busy, (2 * N + 2) * h);
    chk("rises", n_rise, N);
    chk("falls", n_fall, N);
    chk("sclk_span", e_last - e_first, (2 * N - 1) * h);
    chk("nbits", mbits.size(), N);
    mw = '0;
    lw = '0;
    for (int k = 0; k < N && k < mbits.size(); k++) mw[N-1-k] = mbits[k];
    for (int k = 0; k < N && k < lbits.size(); k++) lw[k] = lbits[k];
    chk("mosi_msb_seq", mw, tx);
    chk("mosi_lsb_seq", lw, tx);
    chk("lsb_rx", rx_l, tx);
    cpol = pol; cpha = pha; clk_div = div;
    repeat (3) @(negedge clk);
    chk("one_done", n_done, 1);
  endtask

  initial begin
    int i;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rx", rx_data, 0);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_cs_n", cs_n, 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    xfer(8'hA5, 8'd0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    xfer(8'h3C, 8'd3, 1'b1, 1'b1, 1'b0, 8'hC3, 1'b0);
    xfer(8'h81, 8'd1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
    chk("lsb_first_bit", lbits.size() > 0 ? lbits[0] : 1'bx, 1);
    chk("lsb_second_bit", lbits.size() > 1 ? lbits[1] : 1'bx, 0);
    xfer(8'h81, 8'd0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
    xfer(8'h6E, 8'd2, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1);

    // back-to-back with start held through done
    @(negedge clk);
    cpol = 0; cpha = 0; clk_div = 0; loop = 1;
    m_pol = 0; m_pha = 0; tx_data = 8'h12;
    @(negedge clk);
    clear();
    start = 1'b1;
    @(negedge clk);
    tx_data = 8'h34;
    i = 1;
    while (done !== 1'b1 && i < 40) begin
      @(negedge clk);
      i++;
    end
    chk("b2b_rx1", rx_data, 8'h12);
    chk("b2b_cs_gap", cs_n, 1);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_cs_low", cs_n, 0);
    chk("b2b_busy", busy, 1);
    i = 1;
    while (done !== 1'b1 && i < 40) begin
      @(negedge clk);
      i++;
    end
    chk("b2b_latency", i, 2 * N + 3);
    chk("b2b_rx2", rx_data, 8'h34);
    repeat (2) @(negedge clk);
    chk("b2b_dones", n_done, 2);

    // reset in the middle of a transfer
    @(negedge clk);
    cpol = 0; cpha = 0; clk_div = 1; loop = 1;
    m_pol = 0; m_pha = 0; tx_data = 8'h96;
    @(negedge clk);
    clear();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    i = 0;
    while (n_rise + n_fall < 5 && i < 200) begin
      @(negedge clk);
      i++;
    end
    chk("rst_at_edge5", n_rise + n_fall, 5);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_cs_n", cs_n, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sclk", sclk, 0);
    chk("mid_rst_rx", rx_data, 0);
    chk("mid_rst_done", done, 0);
    rst = 1'b0;
    n_done = 0;
    repeat (40) @(negedge clk);
    chk("mid_rst_nodone", n_done, 0);
    xfer(8'h5A, 8'd0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);

    // largest divider
    xfer(8'($urandom), 8'hFF, 1'b0, 1'b1, 1'b0, 8'($urandom), 1'b0);

    for (int k = 0; k < 8; k++) begin
      xfer(8'($urandom), 8'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master_core.md
Name: spi_master_core

Overview:
- Byte-oriented SPI master; the DUT core driven directly by the bench clock/reset generator (consumes `clk`/`rst`, drives the SPI pins the slave model and monitor observe).
- Accepts one word per `start` request and serialises it on `mosi` while capturing `miso`.
- Supports all four CPOL/CPHA modes and a programmable SCLK divider; reports completion with a `done` pulse and the received word.

Parameters:
- `DATA_W`, 8, bits per transfer (2..32).
- `DIV_W`, 8, width of the `clk_div` input.
- `LSB_FIRST`, 0, 0 = MSB shifted first, 1 = LSB shifted first (applies to both tx and rx).

Ports:
- `clk` input 1: system clock; all logic on its rising edge.
- `rst` input 1: synchronous reset, active-high.
- `start` input 1: transfer request; sampled only in IDLE.
- `tx_data` input DATA_W: word to transmit; latched when `start` is accepted.
- `clk_div` input DIV_W: half-period select, H = `clk_div`+1 clk cycles; latched at accept.
- `cpol` input 1: SCLK idle level.
- `cpha` input 1: 0 = sample on leading edge, 1 = sample on trailing edge; latched at accept.
- `miso` input 1: serial data from slave.
- `busy` output 1: high while the FSM is not in IDLE.
- `done` output 1: one-cycle pulse when a transfer completes.
- `rx_data` output DATA_W: last received word; updated in the same cycle `done` rises.
- `sclk` output 1: SPI clock (registered).
- `mosi` output 1: serial data to slave (registered).
- `cs_n` output 1: active-low chip select (registered).

Behaviour:
- Reset values (`rst`=1 at a clk edge): `busy`=0, `done`=0, `rx_data`=0, `sclk`=0, `mosi`=0, `cs_n`=1, FSM=IDLE, all counters 0.
- Reset overrides everything, including mid-transfer: `cs_n` returns high on the next edge and no `done` pulse is issued.
- FSM states:
  - IDLE: `sclk` <= `cpol` (live input) every cycle; `mosi` <= 0; `cs_n`=1. If `start`=1, latch `tx_data`, `clk_div`, `cpol` and `cpha`, then go to SETUP.
  - SETUP: lasts H cycles; `cs_n`=0, `sclk` held at latched cpol. If cpha=0, `mosi` carries bit 0 of the shift order from the first SETUP cycle.
  - XFER: generates 2*DATA_W SCLK edges, one every H cycles. The first edge is the leading edge and edges alternate leading/trailing; after the last trailing edge go to HOLD.
  - HOLD: lasts H cycles; `sclk` = latched cpol, `cs_n`=0. On exit: `cs_n`=1, `done`=1 for one cycle, `rx_data` <= shift register, then go to IDLE.
- cpha=0 edge actions:
  - `miso` is sampled on every leading edge.
  - `mosi` advances to the next bit on every trailing edge except the last.
- cpha=1 edge actions:
  - `mosi` advances on every leading edge; on the first leading edge it takes bit 0.
  - `miso` is sampled on every trailing edge.
- Sampling is done on the clk edge that toggles `sclk`, using the current `miso` value.
- Timing:
  - `busy` is high for exactly (2*DATA_W+2)*H cycles, starting the cycle after the accept edge.
  - `done` rises in the first IDLE cycle, (2*DATA_W+2)*H+1 cycles after the accept edge.
  - SCLK period = 2*H clk cycles.
- Boundary conditions:
  - `start` while `busy` is ignored; no queuing.
  - `start` in the cycle `done` is high is accepted, allowing back-to-back transfers with `cs_n` high for exactly 1 cycle between them.
  - Changes to `tx_data`, `clk_div`, `cpol` or `cpha` after accept do not affect the current transfer.
  - `clk_div`=0 gives H=1, so `sclk` = clk/2.
  - `clk_div`=all-ones gives H=2^DIV_W; the half-period counter must not overflow.
- Shift width: exactly DATA_W bits transmitted and DATA_W bits captured; `rx_data` holds its value until the next `done`.

Test Plan:
- Mode 0, DATA_W=8, `clk_div`=0, `tx_data`=0xA5, `mosi` looped to `miso` -> 8 rising/8 falling `sclk` edges, `sclk` low at idle, `busy` high for 18 cycles, `done` 19 cycles after start, `rx_data`=0xA5.
- Mode 3, `clk_div`=3, `tx_data`=0x3C, slave model returns 0xC3 -> `sclk` idles high with period 8 clk, `mosi` changes on falling edges, `rx_data`=0xC3, `busy` for 72 cycles.
- Mode 1 and mode 2, `tx_data`=0x81, loopback -> `rx_data`=0x81. With `LSB_FIRST`=1, the first `mosi` bit is 1 and the second is 0.
- `start` pulsed again mid-transfer with `tx_data`=0xFF -> ignored; the original word is shifted out and exactly one `done` is issued.
- `start` held high across `done` for two words 0x12 then 0x34 -> second accepted on the `done` cycle, `cs_n` high 1 cycle, two `done` pulses, final `rx_data`=0x34 (loopback).
- `rst` asserted at the 5th SCLK edge -> next cycle `cs_n`=1, `busy`=0, `sclk`=0, `rx_data`=0, no `done`. A subsequent 0x5A transfer completes with `rx_data`=0x5A.
